// File: rtl/gradient_pkg.sv
// Shared mode encodings and helper arithmetic for the gradient painter.
// Helpers use 32-bit working values so they stay parameter-independent; CHAN_BITS must be <= 31.
package gradient_pkg;

    localparam logic [1:0] MODE_STATIC   = 2'd0;
    localparam logic [1:0] MODE_SCROLL_X = 2'd1;
    localparam logic [1:0] MODE_SCROLL_Y = 2'd2;
    localparam logic [1:0] MODE_DIM      = 2'd3;

    // Replicate the lo_bits-wide value MSB-first until chan_bits are filled; last copy truncated.
    function automatic logic [31:0] expand_lo(input logic [31:0] lo, input int lo_bits,
                                              input int chan_bits);
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < chan_bits) begin
                res = res | (((lo >> (lo_bits - 1 - (i % lo_bits))) & 32'd1) << (chan_bits - 1 - i));
            end
        end
        return res;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int chan_bits);
        logic [32:0] sum;
        logic [32:0] max;
        sum = {1'b0, a} + {1'b0, b};
        max = (33'd1 << chan_bits) - 33'd1;
        return (sum > max) ? max[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/gradient_phase_ctr.sv
// Frame-change detector: latches mode and advances the scroll phase every 2^SCROLL_DIV frame changes.
// Phase/mode update one cycle after the frame input changes; pixels in flight see the old values.
module gradient_phase_ctr
    import gradient_pkg::*;
#(
    parameter int COORD_BITS = 6,
    parameter int FRAME_BITS = 6,
    parameter int SCROLL_DIV = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [FRAME_BITS-1:0] frame_i,
    input  logic [1:0]            mode_i,
    output logic [COORD_BITS-1:0] phase_o,
    output logic [1:0]            mode_o
);

    localparam int DIV_W = (SCROLL_DIV > 0) ? SCROLL_DIV : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'((1 << SCROLL_DIV) - 1);

    logic [FRAME_BITS-1:0] frame_q;
    logic [DIV_W-1:0]      div_q;
    logic [COORD_BITS-1:0] phase_q;
    logic [1:0]            mode_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            frame_q <= frame_i;
            div_q   <= '0;
            phase_q <= '0;
            mode_q  <= MODE_STATIC;
        end else begin
            frame_q <= frame_i;
            if (frame_i != frame_q) begin
                mode_q <= mode_i;
                if (div_q == DIV_MAX) begin
                    div_q   <= '0;
                    phase_q <= phase_q + COORD_BITS'(1);
                end else begin
                    div_q <= div_q + DIV_W'(1);
                end
            end
        end
    end

    assign phase_o = phase_q;
    assign mode_o  = mode_q;

endmodule

// File: rtl/gradient_painter.sv
// Pipelined (x,y)->RGB cell-gradient painter; latency 2, or 3 with GRADIENT_PAINTER_GAMMA_EN.
// One pixel per cycle, no backpressure; rgb holds its last value while out_valid is low.
module gradient_painter
    import gradient_pkg::*;
#(
    parameter int COORD_BITS = 6,
    parameter int CELL_BITS  = 3,
    parameter int CHAN_BITS  = 8,
    parameter int FRAME_BITS = 6,
    parameter int SCROLL_DIV = 2,
    parameter int DIM_LEVEL  = 12
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [FRAME_BITS-1:0]  frame,
    input  logic [1:0]             mode,
    input  logic                   in_valid,
    input  logic [COORD_BITS-1:0]  x,
    input  logic [COORD_BITS-1:0]  y,
    output logic                   out_valid,
    output logic [3*CHAN_BITS-1:0] rgb
);

    logic [COORD_BITS-1:0] phase;
    logic [1:0]            mode_q;

    gradient_phase_ctr #(
        .COORD_BITS(COORD_BITS),
        .FRAME_BITS(FRAME_BITS),
        .SCROLL_DIV(SCROLL_DIV)
    ) u_phase_ctr (
        .clk    (clk),
        .resetn (resetn),
        .frame_i(frame),
        .mode_i (mode),
        .phase_o(phase),
        .mode_o (mode_q)
    );

    // Stage 1: scroll offset; dim flag travels with the pixel so a later mode change cannot hit it.
    logic                  s1_vld_q;
    logic                  s1_dim_q;
    logic [COORD_BITS-1:0] xs_q, ys_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_vld_q <= 1'b0;
            s1_dim_q <= 1'b0;
            xs_q     <= '0;
            ys_q     <= '0;
        end else begin
            s1_vld_q <= in_valid;
            s1_dim_q <= (mode_q == MODE_DIM);
            xs_q     <= (mode_q == MODE_SCROLL_X) ? x + phase : x;
            ys_q     <= (mode_q == MODE_SCROLL_Y) ? y + phase : y;
        end
    end

    logic [31:0]            x_lo, y_lo;
    logic [2:0]             col_b, row_b;
    logic                   blank;
    logic [CHAN_BITS-1:0]   ch [3];
    logic [3*CHAN_BITS-1:0] rgb_d;

    always_comb begin
        x_lo  = expand_lo(32'(xs_q[CELL_BITS-1:0]), CELL_BITS, CHAN_BITS);
        y_lo  = expand_lo(32'(ys_q[CELL_BITS-1:0]), CELL_BITS, CHAN_BITS);
        col_b = 3'(xs_q[COORD_BITS-1:CELL_BITS]);
        row_b = 3'(ys_q[COORD_BITS-1:CELL_BITS]);
        blank = (xs_q[CELL_BITS-1:0] == '0) || (ys_q[CELL_BITS-1:0] == '0);
        for (int c = 0; c < 3; c++) begin
            ch[c] = CHAN_BITS'(sat_add(row_b[c] ? y_lo : 32'd0, col_b[c] ? x_lo : 32'd0,
                                       CHAN_BITS));
            if (s1_dim_q) begin
                ch[c] = CHAN_BITS'(DIM_LEVEL);
            end else if (blank) begin
                ch[c] = '0;
            end
        end
        rgb_d = {ch[0], ch[1], ch[2]};
    end

    logic                   s2_vld_q;
    logic [3*CHAN_BITS-1:0] s2_rgb_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s2_vld_q <= 1'b0;
            s2_rgb_q <= '0;
        end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_rgb_q <= rgb_d;
            end
        end
    end

`ifdef GRADIENT_PAINTER_GAMMA_EN
    logic                   g_vld_q;
    logic [3*CHAN_BITS-1:0] g_rgb_q, g_rgb_d;
    logic [2*CHAN_BITS-1:0] g_sq;

    always_comb begin
        g_rgb_d = '0;
        g_sq    = '0;
        for (int c = 0; c < 3; c++) begin
            g_sq = {{CHAN_BITS{1'b0}}, s2_rgb_q[c*CHAN_BITS +: CHAN_BITS]}
                 * {{CHAN_BITS{1'b0}}, s2_rgb_q[c*CHAN_BITS +: CHAN_BITS]};
            g_rgb_d[c*CHAN_BITS +: CHAN_BITS] = g_sq[2*CHAN_BITS-1:CHAN_BITS];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            g_vld_q <= 1'b0;
            g_rgb_q <= '0;
        end else begin
            g_vld_q <= s2_vld_q;
            if (s2_vld_q) begin
                g_rgb_q <= g_rgb_d;
            end
        end
    end

    assign out_valid = g_vld_q;
    assign rgb       = g_rgb_q;
`else
    assign out_valid = s2_vld_q;
    assign rgb       = s2_rgb_q;
`endif

endmodule

// File: tb/tb_gradient_painter.sv
// Directed bench for gradient_painter with SCROLL_DIV=0 (phase steps on every frame change).
module tb_gradient_painter;

`ifdef GRADIENT_PAINTER_GAMMA_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic [5:0]  frame;
    logic [1:0]  mode;
    logic        in_valid;
    logic [5:0]  x, y;
    logic        out_valid;
    logic [23:0] rgb;

    int n_cmp = 0;
    int n_bad = 0;

    gradient_painter #(
        .COORD_BITS(6), .CELL_BITS(3), .CHAN_BITS(8),
        .FRAME_BITS(6), .SCROLL_DIV(0), .DIM_LEVEL(12)
    ) dut (
        .clk(clk), .resetn(resetn), .frame(frame), .mode(mode),
        .in_valid(in_valid), .x(x), .y(y), .out_valid(out_valid), .rgb(rgb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Expected output after the optional gamma stage: v -> (v*v)>>8 per channel.
    function automatic logic [23:0] gam(input logic [23:0] v);
`ifdef GRADIENT_PAINTER_GAMMA_EN
        logic [23:0] r;
        logic [15:0] s;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            s = {8'd0, v[c*8 +: 8]} * {8'd0, v[c*8 +: 8]};
            r[c*8 +: 8] = s[15:8];
        end
        return r;
`else
        return v;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_change();
        frame = frame + 6'd1;
        step();
    endtask

    task automatic pixel(input string tag, input logic [5:0] px, input logic [5:0] py,
                         input logic [23:0] lin);
        int lat;
        x = px;
        y = py;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            step();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(LAT));
        chk({tag, "_rgb"}, {8'd0, rgb}, {8'd0, gam(lin)});
    endtask

    initial begin
        int stale;
        resetn = 1'b0; frame = '0; mode = 2'd0; in_valid = 1'b0; x = '0; y = '0;
        repeat (3) step();
        chk("rst_vld", {31'd0, out_valid}, 32'd0);
        chk("rst_rgb", {8'd0, rgb}, 32'd0);
        resetn = 1'b1;
        step();

        // Static mode: gradients, saturation, blanking, each channel
        pixel("s_13_9",  6'd13, 6'd9,  24'hDA0000);
        pixel("s_15_15", 6'd15, 6'd15, 24'hFF0000);
        pixel("s_blank", 6'd8,  6'd9,  24'h000000);
        pixel("s_17_17", 6'd17, 6'd17, 24'h004800);
        pixel("s_57_9",  6'd57, 6'd9,  24'h482424);
        pixel("s_20_42", 6'd20, 6'd42, 24'h499249);

        // Dim mode takes effect on frame change; a mid-frame mode change does not
        mode = 2'd3;
        frame_change();
        pixel("dim", 6'd8, 6'd9, 24'h0C0C0C);
        mode = 2'd0;
        pixel("dim_hold", 6'd8, 6'd9, 24'h0C0C0C);

        // Scroll-x: phase 5 after five frame changes from reset
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        mode = 2'd1;
        repeat (5) frame_change();
        pixel("sx_ph5", 6'd8, 6'd9, 24'hDA0000);
        mode = 2'd2;
        pixel("sx_hold", 6'd8, 6'd9, 24'hDA0000);
        frame_change();
        pixel("sy_ph6", 6'd13, 6'd3, 24'hDA0000);
        mode = 2'd1;
        frame_change();
        pixel("sx_wrap", 6'd62, 6'd9, 24'h240000);

        // Pixel coincident with frame change uses phase 7, not 8
        frame = frame + 6'd1;
        pixel("sim_fc", 6'd6, 6'd9, 24'hDA0000);

        // Reset while streaming
        x = 6'd13; y = 6'd2; in_valid = 1'b1;
        repeat (4) step();
        chk("strm_vld", {31'd0, out_valid}, 32'd1);
        resetn = 1'b0;
        step();
        chk("rst_mid_vld", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_rgb", {8'd0, rgb}, 32'd0);
        in_valid = 1'b0;
        resetn = 1'b1;
        stale = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid) stale++;
        end
        chk("no_stale", 32'(stale), 32'd0);
        mode = 2'd1;
        frame_change();
        pixel("ph_rst", 6'd12, 6'd9, 24'hDA0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
